inv_lift_row: RTL and testbench

//  Inverse LeGall 5/3 lifting engine, the decoder-side counterpart of lift_step.

---
 rtl/lift_pkg.sv | 22 ++
 rtl/inv53_kernel.sv | 36 +++
 rtl/inv_lift_row.sv | 160 ++++++++++++++++
 tb/tb_inv_lift_row.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/lift_pkg.sv
// Shared definitions for the LeGall 5/3 lifting blocks: default widths,
// inverse-engine state encoding and the lifting rounding constants.
package lift_pkg;

   localparam int CW_DEF = 16;   // coefficient width (signed)
   localparam int SW_DEF = 15;   // sample width (signed)

   // Update step: (d[n-1] + d[n] + UPD_RND) >>> UPD_SHIFT
   localparam int UPD_RND   = 2;
   localparam int UPD_SHIFT = 2;
   // Predict step: (x[2n] + x[2n+2]) >>> PRD_SHIFT
   localparam int PRD_SHIFT = 1;

   typedef enum logic [2:0] {
      S_EVEN = 3'd0,   // waiting for s[n]
      S_ODD  = 3'd1,   // waiting for d[n]
      S_EM_O = 3'd2,   // presenting x[2n-1]
      S_EM_E = 3'd3,   // presenting x[2n]
      S_EM_L = 3'd4    // presenting x[N-1], end of row
   } lift_state_t;

endpackage

// File: rtl/inv53_kernel.sv
// Combinational inverse 5/3 lifting kernel. The even output undoes the update
// step; the odd output undoes the predict step. All math is CW+2 bits wide
// with floor (arithmetic) shifts.
module inv53_kernel
   import lift_pkg::*;
#(
   parameter int CW = CW_DEF
) (
   input  logic signed [CW-1:0] s,        // s[n]
   input  logic signed [CW-1:0] d_left,   // d[n-1] (or d[0] at row start)
   input  logic signed [CW-1:0] d_right,  // d[n]
   input  logic signed [CW-1:0] d_mid,    // detail coefficient between the two evens
   input  logic signed [CW+1:0] x_left,   // even sample left of the odd one
   input  logic signed [CW+1:0] x_right,  // even sample right of the odd one
   output logic signed [CW+1:0] x_even,
   output logic signed [CW+1:0] x_odd
);

   localparam int W = CW + 2;

   logic signed [W-1:0] upd_sum_s;
   logic signed [W-1:0] prd_sum_s;

   // Even sample: remove the rounded update contribution from s[n].
   always_comb begin
      upd_sum_s = W'(d_left) + W'(d_right) + W'(UPD_RND);
      x_even    = W'(s) - (upd_sum_s >>> UPD_SHIFT);
   end

   // Odd sample: add back the floor average of the neighbouring evens.
   always_comb begin
      prd_sum_s = x_left + x_right;
      x_odd     = W'(d_mid) + (prd_sum_s >>> PRD_SHIFT);
   end

endmodule

// File: rtl/inv_lift_row.sv
// Inverse LeGall 5/3 row engine. Consumes interleaved s0,d0,s1,d1,... and
// emits x0..x(N-1) in natural order over valid/ready handshakes. Input is
// back-pressured whenever a reconstructed sample is pending.
module inv_lift_row
   import lift_pkg::*;
#(
   parameter int ROW_LEN = 256,
   parameter int CW      = CW_DEF,
   parameter int SW      = SW_DEF
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic signed [CW-1:0] in_data,
   input  logic                 in_valid,
   output logic                 in_ready,
   output logic signed [SW-1:0] out_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic                 out_eol
);

   localparam int W  = CW + 2;
   localparam int NW = $clog2(ROW_LEN / 2);
   localparam logic [NW-1:0] N_LAST = NW'(ROW_LEN / 2 - 1);

   lift_state_t          state_r;
   logic [NW-1:0]        n_r;
   logic signed [CW-1:0] s_r;        // s[n]
   logic signed [CW-1:0] d_r;        // most recent detail coefficient
   logic signed [W-1:0]  xe_r;       // most recent even sample
   logic                 in_ready_r;
   logic                 out_valid_r;
   logic                 out_eol_r;
   logic signed [SW-1:0] out_data_r;

   logic signed [CW-1:0] k_dl_s;
   logic signed [W-1:0]  k_xr_s;
   logic signed [W-1:0]  x_even_s;
   logic signed [W-1:0]  x_odd_s;

   // Truncate an internal-width sample to the output width (wraps, no clamp).
   function automatic logic signed [SW-1:0] to_sample(input logic signed [W-1:0] v);
      return v[SW-1:0];
   endfunction

   // Left detail neighbour: symmetric extension d[-1] = d[0] on the first pair.
   always_comb begin
      k_dl_s = d_r;
      if (n_r == {NW{1'b0}}) begin
         k_dl_s = in_data;
      end else begin
         k_dl_s = d_r;
      end
   end

   // Right even neighbour: the freshly computed x[2n] while capturing d[n],
   // otherwise xe_r itself (x[N] = x[N-2] for the last odd sample).
   always_comb begin
      k_xr_s = xe_r;
      if (state_r == S_ODD) begin
         k_xr_s = x_even_s;
      end else begin
         k_xr_s = xe_r;
      end
   end

   inv53_kernel #(.CW(CW)) u_kernel (
      .s       (s_r),
      .d_left  (k_dl_s),
      .d_right (in_data),
      .d_mid   (d_r),
      .x_left  (xe_r),
      .x_right (k_xr_s),
      .x_even  (x_even_s),
      .x_odd   (x_odd_s)
   );

   // Row sequencer: capture s/d pairs, then present the reconstructed samples.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= S_EVEN;
         n_r         <= {NW{1'b0}};
         s_r         <= {CW{1'b0}};
         d_r         <= {CW{1'b0}};
         xe_r        <= {W{1'b0}};
         in_ready_r  <= 1'b0;
         out_valid_r <= 1'b0;
         out_eol_r   <= 1'b0;
         out_data_r  <= {SW{1'b0}};
      end else begin
         case (state_r)
            S_EVEN: begin
               in_ready_r <= 1'b1;
               if (in_valid && in_ready_r) begin
                  s_r     <= in_data;
                  state_r <= S_ODD;
               end
            end
            S_ODD: begin
               if (in_valid && in_ready_r) begin
                  d_r         <= in_data;
                  xe_r        <= x_even_s;
                  in_ready_r  <= 1'b0;
                  out_valid_r <= 1'b1;
                  out_eol_r   <= 1'b0;
                  if (n_r == {NW{1'b0}}) begin
                     out_data_r <= to_sample(x_even_s);
                     state_r    <= S_EM_E;
                  end else begin
                     out_data_r <= to_sample(x_odd_s);
                     state_r    <= S_EM_O;
                  end
               end
            end
            S_EM_O: begin
               if (out_ready) begin
                  out_data_r <= to_sample(xe_r);
                  state_r    <= S_EM_E;
               end
            end
            S_EM_E: begin
               if (out_ready) begin
                  if (n_r == N_LAST) begin
                     out_data_r <= to_sample(x_odd_s);
                     out_eol_r  <= 1'b1;
                     state_r    <= S_EM_L;
                  end else begin
                     n_r         <= n_r + NW'(1);
                     out_valid_r <= 1'b0;
                     in_ready_r  <= 1'b1;
                     state_r     <= S_EVEN;
                  end
               end
            end
            S_EM_L: begin
               if (out_ready) begin
                  n_r         <= {NW{1'b0}};
                  out_valid_r <= 1'b0;
                  out_eol_r   <= 1'b0;
                  in_ready_r  <= 1'b1;
                  state_r     <= S_EVEN;
               end
            end
            default: begin
               state_r     <= S_EVEN;
               n_r         <= {NW{1'b0}};
               in_ready_r  <= 1'b0;
               out_valid_r <= 1'b0;
               out_eol_r   <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_r;
   assign out_valid = out_valid_r;
   assign out_eol   = out_eol_r;
   assign out_data  = out_data_r;

endmodule

// File: tb/tb_inv_lift_row.sv
// Self-checking bench for inv_lift_row (ROW_LEN=8). Directed rows plus random
// round trips: random samples are forward-transformed in the bench and the
// engine must return the original samples exactly.
module tb_inv_lift_row;

   localparam int N  = 8;
   localparam int CW = 16;
   localparam int SW = 15;

   typedef int row_t [N];

   logic                 clk;
   logic                 rst_n;
   logic signed [CW-1:0] in_data;
   logic                 in_valid;
   logic                 in_ready;
   logic signed [SW-1:0] out_data;
   logic                 out_valid;
   logic                 out_ready;
   logic                 out_eol;

   int n_cmp;
   int n_bad;

   inv_lift_row #(.ROW_LEN(N), .CW(CW), .SW(SW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_eol   (out_eol)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input int obs, input int exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Forward 5/3 transform of a sample row into interleaved s,d coefficients.
   function automatic void fwd_model(input row_t x, output row_t c);
      int d [N/2];
      for (int n = 0; n < N/2; n++) begin
         int xn = (2*n + 2 < N) ? x[2*n + 2] : x[N - 2];
         d[n] = x[2*n + 1] - ((x[2*n] + xn) >>> 1);
      end
      for (int n = 0; n < N/2; n++) begin
         int dm = (n == 0) ? d[0] : d[n - 1];
         c[2*n]     = x[2*n] + ((dm + d[n] + 2) >>> 2);
         c[2*n + 1] = d[n];
      end
   endfunction

   function automatic int wrap_sw(input int v);
      logic signed [SW-1:0] t;
      t = v[SW-1:0];
      return int'(t);
   endfunction

   // Inverse 5/3 transform straight from the reconstruction equations.
   function automatic void inv_model(input row_t c, output row_t x);
      int xe [N/2];
      for (int n = 0; n < N/2; n++) begin
         int dm = (n == 0) ? c[1] : c[2*n - 1];
         xe[n] = c[2*n] - ((dm + c[2*n + 1] + 2) >>> 2);
      end
      for (int n = 0; n < N/2; n++) begin
         int xr = (n + 1 < N/2) ? xe[n + 1] : xe[n];
         x[2*n]     = wrap_sw(xe[n]);
         x[2*n + 1] = wrap_sw(c[2*n + 1] + ((xe[n] + xr) >>> 1));
      end
   endfunction

   // Push one row and collect stop_after outputs.
   // mode 0: sink always ready, 1: sink toggles each cycle, 2: random both sides.
   task automatic run_row(input row_t cin, input row_t exp, input int mode, input int stop_after);
      int  ii  = 0;
      int  k   = 0;
      int  cyc = 0;
      bit  tog = 1'b1;
      while (k < stop_after && cyc < 400) begin
         @(negedge clk);
         cyc++;
         in_valid = (ii < N) && (mode != 2 || $urandom_range(3) != 0);
         in_data  = (ii < N) ? CW'(cin[ii]) : {CW{1'b0}};
         case (mode)
            0:       out_ready = 1'b1;
            1:       begin out_ready = tog; tog = !tog; end
            default: out_ready = 1'($urandom_range(1));
         endcase
         if (out_valid) begin
            check("in_ready_while_out_valid", int'(in_ready), 0);
         end
         if (in_valid && in_ready) begin
            ii++;
         end
         if (out_valid && out_ready) begin
            check($sformatf("x[%0d]", k), int'(out_data), exp[k]);
            check($sformatf("eol[%0d]", k), int'(out_eol), (k == N - 1) ? 1 : 0);
            k++;
         end
      end
      if (k < stop_after) begin
         check("row_timeout", k, stop_after);
      end
      @(posedge clk);
      #1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_out_valid"}, int'(out_valid), 0);
      check({tag, "_out_data"},  int'(out_data), 0);
      check({tag, "_out_eol"},   int'(out_eol), 0);
      check({tag, "_in_ready"},  int'(in_ready), 0);
   endtask

   initial begin
      row_t c_const, x_const, c_ramp, x_ramp, c_neg, x_neg, xs, cs;
      n_cmp     = 0;
      n_bad     = 0;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = {CW{1'b0}};
      out_ready = 1'b0;

      c_const = '{100, 0, 100, 0, 100, 0, 100, 0};
      x_const = '{100, 100, 100, 100, 100, 100, 100, 100};
      c_ramp  = '{0, 0, 2, 0, 4, 0, 6, 1};
      x_ramp  = '{0, 1, 2, 3, 4, 5, 6, 7};
      c_neg   = '{-4, -2, -4, -2, -4, -2, -4, -2};
      inv_model(c_neg, x_neg);

      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      rst_n = 1'b1;

      run_row(c_const, x_const, 0, N);
      run_row(c_ramp,  x_ramp,  0, N);
      run_row(c_ramp,  x_ramp,  1, N);

      // Reset in the middle of a row; the next row must be clean.
      run_row(c_ramp, x_ramp, 0, 3);
      rst_n = 1'b0;
      @(negedge clk);
      check_reset_outputs("midrow_reset");
      rst_n = 1'b1;
      run_row(c_const, x_const, 0, N);

      run_row(c_neg, x_neg, 1, N);

      // Extreme-value rows, round trip.
      for (int e = 0; e < 3; e++) begin
         for (int i = 0; i < N; i++) begin
            case (e)
               0:       xs[i] = -16384;
               1:       xs[i] = 16383;
               default: xs[i] = (i % 2 == 0) ? -16384 : 16383;
            endcase
         end
         fwd_model(xs, cs);
         run_row(cs, xs, 0, N);
      end

      // Random round trips with random handshakes.
      for (int r = 0; r < 40; r++) begin
         for (int i = 0; i < N; i++) begin
            xs[i] = int'($urandom_range(32767)) - 16384;
         end
         fwd_model(xs, cs);
         run_row(cs, xs, 2, N);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
